// File: rtl/flow_arb_pkg.sv
// Shared constants for the flow-control read-side arbiter.
// Optional grant statistics are enabled with the ARB_STATS_EN macro (see flow_arbiter).
package flow_arb_pkg;
    localparam int NUM_Q          = 4;
    localparam int DEFAULT_WEIGHT = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    function automatic logic [NUM_Q-1:0] q_onehot(input logic [1:0] idx);
        q_onehot = 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/flow_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible queue at or after the start pointer.
module rr_pick
    import flow_arb_pkg::*;
(
    input  logic [NUM_Q-1:0] elig,
    input  logic [1:0]       start,
    output logic [NUM_Q-1:0] grant,
    output logic [1:0]       idx,
    output logic             found
);

    logic [1:0] cand;

    // Scan offsets high to low so the nearest eligible queue is the last one written.
    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            cand = start + 2'(k);
            if (elig[cand]) begin
                idx   = cand;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
        if (found) begin
            grant = q_onehot(idx);
        end else begin
            grant = 4'b0000;
        end
    end

endmodule

// File: rtl/flow_arbiter.sv
// Weighted round-robin read scheduler for four VC input FIFOs feeding one output FIFO.
// Define ARB_STATS_EN to add per-queue saturating grant counters (stat_sel/stat_cnt).
module flow_arbiter
    import flow_arb_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  idle,
    input  logic [3:0]            continuar,
    input  logic [3:0]            error_full,
    input  logic [3:0]            empty_in,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic                  out_almost_full,
    input  logic                  wt_wr,
    input  logic [1:0]            wt_addr,
    input  logic [WEIGHT_W-1:0]   wt_data,
    output logic [3:0]            pop,
    output logic [DATA_W-1:0]     data_out,
    output logic                  push_out,
    output logic                  arb_err
`ifdef ARB_STATS_EN
    ,
    input  logic [1:0]            stat_sel,
    output logic [15:0]           stat_cnt
`endif
);

    logic [1:0]          state_r;
    logic [1:0]          ptr_r;
    logic [WEIGHT_W-1:0] credit_r;
    logic [WEIGHT_W-1:0] weight_r [NUM_Q];
    logic                p1_valid_r;
    logic [1:0]          p1_idx_r;
    logic                push_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                arb_err_r;

    logic [3:0]          elig_s;
    logic [3:0]          pick_grant_s;
    logic [1:0]          pick_idx_s;
    logic                pick_found_s;
    logic [1:0]          start_s;
    logic [1:0]          next_state_s;
    logic [1:0]          next_ptr_s;
    logic [WEIGHT_W-1:0] next_credit_s;
    logic                grant_s;
    logic [1:0]          grant_idx_s;
    logic [3:0]          pop_s;
    logic [DATA_W-1:0]   word_s;

    // Per-queue eligibility: data present, not in its almost-empty strobe, not disabled.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            elig_s[i] = !empty_in[i] && !continuar[i] && (weight_r[i] != {WEIGHT_W{1'b0}});
        end
    end

    assign start_s = ptr_r + 2'd1;

    rr_pick u_pick (
        .elig  (elig_s),
        .start (start_s),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Scheduling decision: keep spending the current queue's credit, else rotate and reload.
    always_comb begin
        next_state_s  = state_r;
        next_ptr_s    = ptr_r;
        next_credit_s = credit_r;
        grant_s       = 1'b0;
        grant_idx_s   = ptr_r;
        case (state_r)
            S_IDLE: begin
                if (!idle && (|elig_s)) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (out_almost_full || !(|elig_s) || idle) begin
                    next_state_s = S_IDLE;
                end else if (elig_s[ptr_r] && (credit_r != {WEIGHT_W{1'b0}})) begin
                    grant_s       = 1'b1;
                    next_credit_s = credit_r - WEIGHT_W'(1);
                end else begin
                    grant_s       = pick_found_s;
                    grant_idx_s   = pick_idx_s;
                    next_ptr_s    = pick_idx_s;
                    next_credit_s = weight_r[pick_idx_s] - WEIGHT_W'(1);
                end
            end
            S_ERR: begin
                next_state_s = S_ERR;
            end
            default: begin
                next_state_s = S_ERR;
            end
        endcase
        if (enb && grant_s && (error_full == 4'b0000)) begin
            pop_s = q_onehot(grant_idx_s);
        end else begin
            pop_s = 4'b0000;
        end
    end

    assign word_s = data_in[DATA_W*int'(p1_idx_r) +: DATA_W];

    // FSM, grant pointer and credit; an overflow wins over everything, including enb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            ptr_r     <= 2'd0;
            credit_r  <= {WEIGHT_W{1'b0}};
            arb_err_r <= 1'b0;
        end else if (error_full != 4'b0000) begin
            state_r   <= S_ERR;
            arb_err_r <= 1'b1;
        end else if (enb) begin
            state_r   <= next_state_s;
            ptr_r     <= next_ptr_s;
            credit_r  <= next_credit_s;
        end
    end

    // Arbitration table; new weights only matter at the next credit reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_Q; i++) begin
                weight_r[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else if (enb && wt_wr) begin
            weight_r[wt_addr] <= wt_data;
        end
    end

    // Two-stage pop-to-push pipeline; it keeps draining in S_ERR so issued pops complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid_r <= 1'b0;
            p1_idx_r   <= 2'd0;
            push_r     <= 1'b0;
            data_out_r <= {DATA_W{1'b0}};
        end else if (enb) begin
            p1_valid_r <= |pop_s;
            p1_idx_r   <= grant_idx_s;
            push_r     <= p1_valid_r;
            if (p1_valid_r) begin
                data_out_r <= word_s;
            end
        end
    end

    assign pop      = pop_s;
    assign data_out = data_out_r;
    assign push_out = push_r && enb;
    assign arb_err  = arb_err_r;

`ifdef ARB_STATS_EN
    logic [15:0] cnt_r [NUM_Q];

    // Saturating per-queue grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_Q; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (pop_s[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = cnt_r[stat_sel];
`endif

endmodule

// File: tb/tb_flow_arbiter.sv
// Directed self-checking bench for flow_arbiter: WRR order, back-pressure, masking, reset, error.
module tb_flow_arbiter;
    localparam int DATA_W   = 6;
    localparam int WEIGHT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                enb;
    logic                idle;
    logic [3:0]          continuar;
    logic [3:0]          error_full;
    logic [3:0]          empty_in;
    logic [4*DATA_W-1:0] data_in;
    logic                out_almost_full;
    logic                wt_wr;
    logic [1:0]          wt_addr;
    logic [WEIGHT_W-1:0] wt_data;
    logic [3:0]          pop;
    logic [DATA_W-1:0]   data_out;
    logic                push_out;
    logic                arb_err;
`ifdef ARB_STATS_EN
    logic [1:0]          stat_sel = 2'd0;
    logic [15:0]         stat_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    flow_arbiter #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .enb             (enb),
        .idle            (idle),
        .continuar       (continuar),
        .error_full      (error_full),
        .empty_in        (empty_in),
        .data_in         (data_in),
        .out_almost_full (out_almost_full),
        .wt_wr           (wt_wr),
        .wt_addr         (wt_addr),
        .wt_data         (wt_data),
        .pop             (pop),
        .data_out        (data_out),
        .push_out        (push_out),
        .arb_err         (arb_err)
`ifdef ARB_STATS_EN
        ,
        .stat_sel        (stat_sel),
        .stat_cnt        (stat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] qword(input logic [3:0] oh);
        case (oh)
            4'b0001: qword = 6'h11;
            4'b0010: qword = 6'h22;
            4'b0100: qword = 6'h33;
            4'b1000: qword = 6'h0C;
            default: qword = 6'h00;
        endcase
    endfunction

    task automatic wr_weight(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        idle = 1'b1; wt_wr = 1'b1; wt_addr = a; wt_data = d;
        #1 check("pop_during_init", pop, 4'b0000);
        @(negedge clk);
        wt_wr = 1'b0; idle = 1'b0;
        #1 check("pop_idle_wait", pop, 4'b0000);
    endtask

    logic [3:0] seq_a [11] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
    logic [3:0] seq_b [5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] seq_c [8]  = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                               4'b0100, 4'b1000};
    logic [3:0] cont_c [8] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000};

    initial begin
        rst = 1'b0; enb = 1'b1; idle = 1'b1; continuar = 4'b0000; error_full = 4'b0000;
        empty_in = 4'b1111; data_in = {6'h0C, 6'h33, 6'h22, 6'h11};
        out_almost_full = 1'b0; wt_wr = 1'b0; wt_addr = 2'd0; wt_data = 4'd0;
        #12;
        check("rst_pop", pop, 4'b0000);
        check("rst_push", push_out, 1'b0);
        check("rst_data", data_out, 6'h00);
        check("rst_err", arb_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Weights {3,1,1,1}, everything non-empty.
        empty_in = 4'b0000;
        wr_weight(2'd0, 4'd3);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            #1 check("wrr_pop", pop, seq_a[i]);
            if (i >= 2) begin
                check("wrr_push", push_out, 1'b1);
                check("wrr_data", data_out, qword(seq_a[i-2]));
            end
        end

        // Back-pressure with queue 0 holding one remaining credit.
        @(negedge clk);
        out_almost_full = 1'b1;
        #1 check("afull_pop0", pop, 4'b0000);
        check("afull_push0", push_out, 1'b1);
        @(negedge clk);
        #1 check("afull_pop1", pop, 4'b0000);
        check("afull_push1", push_out, 1'b1);
        check("afull_data1", data_out, 6'h11);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("afull_pop_hold", pop, 4'b0000);
            check("afull_push_none", push_out, 1'b0);
        end
        @(negedge clk);
        out_almost_full = 1'b0;
        #1 check("resume_same_q", pop, 4'b0001);
        @(negedge clk);
        #1 check("resume_next_q", pop, 4'b0010);
        @(negedge clk);
        #1 check("pre_rst_pop", pop, 4'b0100);
        check("pre_rst_push", push_out, 1'b1);

        // Reset while traffic is flowing.
        rst = 1'b0;
        #1 check("midrst_pop", pop, 4'b0000);
        check("midrst_push", push_out, 1'b0);
        check("midrst_data", data_out, 6'h00);
        check("midrst_err", arb_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("post_rst_idle", pop, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check("post_rst_w1", pop, seq_b[i]);
        end

        // Queue 2 weight 3; continuar masks it mid-credit.
        wr_weight(2'd2, 4'd3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            continuar = cont_c[i];
            #1 check("cont_pop", pop, seq_c[i]);
        end
        continuar = 4'b0000;

        // Queue 2 disabled, only queues 1 and 2 hold data.
        empty_in = 4'b1001;
        wr_weight(2'd2, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("w0_only_q1", pop, 4'b0010);
        end

        // All eligible weights zero: stays idle.
        wr_weight(2'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("all_w0_idle", pop, 4'b0000);
        end

        // Enable stall: pop suppressed, pending push retained.
        wr_weight(2'd1, 4'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("enb_pre_pop", pop, 4'b0010);
        end
        @(negedge clk);
        enb = 1'b0;
        #1 check("enb_lo_pop", pop, 4'b0000);
        check("enb_lo_push", push_out, 1'b0);
        @(negedge clk);
        enb = 1'b1;
        #1 check("enb_hi_pop", pop, 4'b0010);
        check("enb_hi_push", push_out, 1'b1);
        check("enb_hi_data", data_out, 6'h22);
        @(negedge clk);
        #1 check("enb_hi_pop2", pop, 4'b0010);
        check("enb_hi_push2", push_out, 1'b1);

        // Fatal overflow.
        @(negedge clk);
        error_full = 4'b0001;
        #1 check("err_pop_gated", pop, 4'b0000);
        check("err_flag_before", arb_err, 1'b0);
        @(negedge clk);
        error_full = 4'b0000;
        #1 check("err_flag_set", arb_err, 1'b1);
        check("err_pop0", pop, 4'b0000);
        check("err_drain_push", push_out, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("err_sticky", arb_err, 1'b1);
            check("err_pop_hold", pop, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 check("err_rst_clear", arb_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("err_rst_idle", pop, 4'b0000);
        @(negedge clk);
        #1 check("err_recover_pop", pop, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
